// File: rtl/result_writer_pkg.sv
// Shared types, default frame geometry and the rectify/scale/clamp helper
// for the result_writer back-end.
package result_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned IMG_W_DFLT = 30;
  localparam int unsigned IMG_H_DFLT = 30;
  localparam int unsigned FRAME_PIX  = IMG_W_DFLT * IMG_H_DFLT;

  typedef struct packed {
    logic        clip;
    logic [31:0] pix;
  } clamp_t;

  // Negative results rectify to 0; positive results are shifted down and
  // saturated to the largest pixel value. clip flags either adjustment.
  function automatic clamp_t clamp_pix(input logic signed [31:0] v,
                                       input int unsigned        shift,
                                       input int unsigned        pix_w);
    logic signed [31:0] s;
    logic signed [31:0] maxv;
    clamp_t             r;
    maxv   = (32'sd1 <<< pix_w) - 32'sd1;
    s      = v >>> shift;
    r.clip = 1'b0;
    r.pix  = s;
    if (v < 0) begin
      r.pix  = '0;
      r.clip = 1'b1;
    end else if (s > maxv) begin
      r.pix  = maxv;
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with read/write pointers plus an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointers, occupancy and storage; clr flushes without touching data.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/result_writer.sv
// Converts the signed adder result stream to 8-bit pixels, buffers them and
// writes one frame sequentially into the output RAM, pulsing frame_done at
// the end.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int unsigned IN_W       = 15,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned IMG_W      = IMG_W_DFLT,
  parameter int unsigned IMG_H      = IMG_H_DFLT,
  parameter int unsigned SHIFT      = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_valid,
  input  logic                   mem_ready,
  output logic                   mem_wren,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [PIX_W-1:0]       mem_din,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overflow,
  output logic [ADDR_W-1:0]      clip_count
);

  localparam int unsigned FRAME_N = IMG_W * IMG_H;
  localparam int unsigned CNT_W   = $clog2(FRAME_N + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic               c_valid_q, c_valid_d;
  logic [PIX_W-1:0]   c_pix_q, c_pix_d;
  logic               c_clip_q, c_clip_d;
  logic [ADDR_W-1:0]  addr_cnt_q, addr_cnt_d;
  logic               mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]   mem_din_q, mem_din_d;
  logic               wr_pend_q, wr_pend_d;
  logic               frame_done_q, frame_done_d;
  logic               overflow_q, overflow_d;
  logic [ADDR_W-1:0]  clip_count_q, clip_count_d;

  logic signed [31:0] in_ext;
  clamp_t             conv;
  logic [PIX_W-1:0]   conv_pix;
  logic               fifo_push, fifo_pop, push_ok;
  logic               fifo_full, fifo_empty;
  logic [PIX_W-1:0]   fifo_dout;

  assign in_ext   = 32'(in_data);
  assign conv     = clamp_pix(in_ext, SHIFT, PIX_W);
  assign conv_pix = PIX_W'(conv.pix);

  // start flushes everything, so neither FIFO port moves in that cycle.
  assign fifo_pop  = !fifo_empty && mem_ready && !start;
  assign fifo_push = c_valid_q && !start;
  assign push_ok   = fifo_push && (!fifo_full || fifo_pop);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (c_pix_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, conversion stage, write port and counters.
  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    c_valid_d    = c_valid_q;
    c_pix_d      = c_pix_q;
    c_clip_d     = c_clip_q;
    addr_cnt_d   = addr_cnt_q;
    mem_wren_d   = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    wr_pend_d    = mem_wren_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    clip_count_d = clip_count_q;

    if (push_ok) begin
      c_valid_d = 1'b0;
      if (c_clip_q && (clip_count_q != '1)) begin
        clip_count_d = clip_count_q + 1'b1;
      end
    end

    if (fifo_pop) begin
      mem_wren_d = 1'b1;
      mem_addr_d = addr_cnt_q;
      mem_din_d  = fifo_dout;
      addr_cnt_d = addr_cnt_q + 1'b1;
    end

    case (state_q)
      RUN: begin
        if (in_valid) begin
          in_cnt_d = in_cnt_q + 1'b1;
          // Stage C stalls while its sample cannot enter a full FIFO, so the
          // newly arriving sample is the one that gets dropped.
          if (c_valid_q && !push_ok) begin
            overflow_d = 1'b1;
          end else begin
            c_valid_d = 1'b1;
            c_pix_d   = conv_pix;
            c_clip_d  = conv.clip;
          end
          if (in_cnt_q == CNT_W'(FRAME_N - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // wr_pend covers the RAM commit cycle following the last strobe.
        if (!c_valid_q && fifo_empty && !mem_wren_q && !wr_pend_q) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
      end
    endcase

    if (start) begin
      state_d      = RUN;
      in_cnt_d     = '0;
      c_valid_d    = 1'b0;
      addr_cnt_d   = '0;
      mem_wren_d   = 1'b0;
      mem_addr_d   = '0;
      wr_pend_d    = 1'b0;
      frame_done_d = 1'b0;
      overflow_d   = 1'b0;
      clip_count_d = '0;
    end
  end

  // Pipeline, FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_cnt_q     <= '0;
      c_valid_q    <= 1'b0;
      c_pix_q      <= '0;
      c_clip_q     <= 1'b0;
      addr_cnt_q   <= '0;
      mem_wren_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      wr_pend_q    <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      clip_count_q <= '0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      c_valid_q    <= c_valid_d;
      c_pix_q      <= c_pix_d;
      c_clip_q     <= c_clip_d;
      addr_cnt_q   <= addr_cnt_d;
      mem_wren_q   <= mem_wren_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      wr_pend_q    <= wr_pend_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      clip_count_q <= clip_count_d;
    end
  end

  assign mem_wren   = mem_wren_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign clip_count = clip_count_q;

endmodule
